// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between four requesters.
// It latches the winner's request, runs one memory transaction, then acks the winner.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [3:0]      req,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  input  logic [3:0]      we,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    gnt_n, ack_n;
  logic          err_n, mem_req_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, rdata_n;
  logic [1:0]    win;
  logic          any;
  logic          timed_out;

  // First set request bit scanning upward from the priority pointer.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!any && req[ptr + 2'(k)]) begin
        any = 1'b1;
        win = ptr + 2'(k);
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (cnt == TLAST);

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    gnt_n       = gnt;
    ack_n       = '0;
    err_n       = 1'b0;
    rdata_n     = rdata;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_we_n    = mem_we;
    case (state)
      IDLE: begin
        if (any) begin
          gnt_n       = 4'b0001 << win;
          mem_req_n   = 1'b1;
          mem_addr_n  = addr[win*AW +: AW];
          mem_wdata_n = wdata[win*DW +: DW];
          mem_we_n    = we[win];
          ptr_n       = win + 2'd1;
          cnt_n       = '0;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        // A memory ack on the timeout edge still counts as a normal completion.
        if (mem_ack) begin
          rdata_n   = mem_rdata;
          ack_n     = gnt;
          gnt_n     = '0;
          mem_req_n = 1'b0;
          state_n   = RESP;
        end else if (timed_out) begin
          rdata_n   = '0;
          ack_n     = gnt;
          err_n     = 1'b1;
          gnt_n     = '0;
          mem_req_n = 1'b0;
          state_n   = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      ack       <= ack_n;
      err       <= err_n;
      rdata     <= rdata_n;
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, reset and stray-ack
// sequences, then randomized transactions checked against a round-robin model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            rst_b;
  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      we;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .addr(addr), .wdata(wdata), .we(we),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int ptr_m  = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_rdata;

  typedef struct {
    logic [3:0] r;
    logic [3:0] w;
    int         d;
    logic [3:0] g;
    logic       e;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: rotate the request vector so the pointer sits at bit 0, take the lowest set bit.
  function automatic logic [3:0] model_grant(input logic [3:0] r, input int p);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {r, r} >> p;
    rot = dbl[3:0];
    for (int j = 0; j < 4; j++)
      if (rot[j]) return 4'(1 << ((p + j) % 4));
    return 4'b0000;
  endfunction

  // One full transaction from IDLE; memory acks d cycles after the grant cycle.
  task automatic txn(input logic [3:0] r, input logic [3:0] w, input int d,
                     input logic [3:0] eg, input logic ee, input string tag);
    logic [AW-1:0] a[4];
    logic [DW-1:0] wd[4];
    logic [DW-1:0] rd;
    int wi, busy, bad;
    bit done;
    for (int i = 0; i < 4; i++) begin
      a[i]  = $urandom;
      wd[i] = $urandom;
      addr[i*AW +: AW]  = a[i];
      wdata[i*DW +: DW] = wd[i];
    end
    req = r;
    we  = w;
    rd  = $urandom;
    wi  = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) wi = i;
    @(posedge clk); #1;
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_mem_addr"}, mem_addr, a[wi]);
    chk({tag, "_mem_wdata"}, mem_wdata, wd[wi]);
    chk({tag, "_mem_we"}, mem_we, w[wi]);
    ptr_m = (wi + 1) % 4;
    // Requester side churns during BUSY; none of it may reach the port.
    req = 4'($urandom);
    we  = 4'($urandom);
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = $urandom;
    busy = 1;
    bad  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == d) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (ack != 4'b0000) done = 1'b1;
      else begin
        busy++;
        if (gnt !== eg || mem_req !== 1'b1 || mem_addr !== a[wi]) bad++;
      end
    end
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_busy_hold"}, bad, 0);
    chk({tag, "_busy_len"}, busy, ee ? TO : d + 1);
    chk({tag, "_ack"}, ack, eg);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_rdata"}, rdata, ee ? '0 : rd);
    chk({tag, "_resp_gnt"}, {gnt, 3'b0, mem_req}, 0);
    last_addr  = a[wi];
    last_rdata = ee ? '0 : rd;
    req = 4'($urandom);
    @(posedge clk); #1;
    chk({tag, "_idle_outs"}, {ack, gnt, 3'b0, err, 3'b0, mem_req}, 0);
  endtask

  task automatic idle_stray(input string tag);
    req       = 4'b0000;
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk({tag, "_stray_ctrl"}, {ack, gnt, 3'b0, err, 3'b0, mem_req}, 0);
    chk({tag, "_stray_addr"}, mem_addr, last_addr);
    chk({tag, "_stray_rdata"}, rdata, last_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] r, eg;
    int d;
    tbl[0]  = '{4'b0010, 4'b0000,  3, 4'b0010, 1'b0};
    tbl[1]  = '{4'b1001, 4'b0001,  1, 4'b1000, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0101,  1, 4'b0001, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0101,  1, 4'b0010, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0101,  1, 4'b0100, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0101,  1, 4'b1000, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0101,  1, 4'b0001, 1'b0};
    tbl[7]  = '{4'b0100, 4'b0100, 99, 4'b0100, 1'b1};
    tbl[8]  = '{4'b1001, 4'b0000,  0, 4'b1000, 1'b0};
    tbl[9]  = '{4'b0110, 4'b0010, 15, 4'b0010, 1'b0};
    tbl[10] = '{4'b0011, 4'b0001, 16, 4'b0001, 1'b1};
    tbl[11] = '{4'b1110, 4'b1000,  2, 4'b0010, 1'b0};

    rst_b     = 1'b0;
    req       = '0;
    addr      = '0;
    wdata     = '0;
    we        = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #12;
    chk("reset_ctrl", {ack, gnt, 3'b0, err, 2'b0, mem_req, mem_we}, 0);
    chk("reset_data", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", rdata, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    ptr_m      = 0;
    last_addr  = '0;
    last_rdata = '0;

    for (int i = 0; i < 12; i++)
      txn(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].g, tbl[i].e, $sformatf("vec%0d", i));

    idle_stray("idle0");
    idle_stray("idle1");

    // Asynchronous reset in the middle of a transaction.
    req  = 4'b0001;
    addr = {4{32'h1234_5678}};
    we   = 4'b0001;
    @(posedge clk); #1;
    chk("rst_mid_busy", mem_req, 1);
    req = 4'b1111;
    #1 rst_b = 1'b0;
    #1;
    chk("rst_mid_ctrl", {ack, gnt, 3'b0, err, 2'b0, mem_req, mem_we}, 0);
    chk("rst_mid_data", {mem_addr, mem_wdata, rdata}, 0);
    @(posedge clk); #1;
    chk("rst_held_gnt", gnt, 0);
    rst_b = 1'b1;
    ptr_m = 0;
    last_rdata = '0;
    txn(4'b1111, 4'b0000, 2, 4'b0001, 1'b0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_stray($sformatf("rnd%0d", n));
      r  = 4'($urandom_range(1, 15));
      eg = model_grant(r, ptr_m);
      d  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 6));
      txn(r, 4'($urandom), d, eg, d >= TO, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter sharing one memory port between four requesters, e.g. instruction fetch, load/store, DMA and debug. It latches the winner's address, write data and write enable, then drives a single memory transaction. It waits for the memory acknowledge or a timeout, then returns read data and a one-cycle acknowledge to the winner. It sits between the core datapath and the memory interface.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max BUSY cycles before abort; 0 disables timeout
CW, 8, timeout counter width; must satisfy TIMEOUT < 2^CW

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
req  input  4  request per requester, level
addr  input  4*AW  packed addresses, requester i at [i*AW +: AW]
wdata  input  4*DW  packed write data, requester i at [i*DW +: DW]
we  input  4  write enable per requester
gnt  output  4  one-hot grant, high throughout BUSY
ack  output  4  one-hot, one-cycle completion pulse
rdata  output  DW  read data, valid while ack is nonzero
err  output  1  pulses with ack when the transaction timed out
mem_req  output  1  memory request, high throughout BUSY
mem_addr  output  AW  latched address
mem_wdata  output  DW  latched write data
mem_we  output  1  latched write enable
mem_ack  input  1  memory completion, sampled in BUSY only
mem_rdata  input  DW  memory read data, sampled with mem_ack

Behaviour:
- All outputs are registered.
- Reset (async, rst_b=0):
  - State=IDLE.
  - gnt, ack, err, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
  - Priority pointer=0, so requester 0 has highest priority.
  - Timeout counter=0.
  - Reset mid-transaction abandons it silently; no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If req != 0, choose the winner by scanning indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - At the next edge: gnt = onehot(winner); mem_req=1; mem_addr/mem_wdata/mem_we latched from the winner's slice; ptr = (winner+1) mod 4; counter cleared; go to BUSY.
  - If req == 0, stay in IDLE; outputs are unchanged except ack/err=0.
- BUSY:
  - Inputs are ignored; requester-side req/addr/wdata/we may change or drop without effect, and the transaction still completes.
  - mem_ack=1 at an edge: rdata=mem_rdata; ack=gnt; err=0; gnt=0; mem_req=0; go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: rdata=0; ack=gnt; err=1; gnt=0; mem_req=0; go to RESP.
  - Else counter increments.
- RESP:
  - ack/err are high for exactly this cycle.
  - Next edge: ack=0, err=0, go to IDLE.
  - No arbitration happens in RESP.
- Latency:
  - req seen at edge 0 gives gnt/mem_req at cycle 1.
  - mem_ack sampled at edge k gives ack at cycle k+1; IDLE at k+2.
  - A held req is re-granted at k+3 at the earliest.
- Requester protocol:
  - Hold req, addr, wdata and we stable until gnt is seen.
  - Drop req in the ack cycle unless another transaction is wanted.
  - A req still high in IDLE is treated as a new request.
- mem_ack outside BUSY is ignored.
- Fairness: any continuously asserted req is granted within 4 transactions.
- Invariants: gnt and ack are always one-hot or zero; gnt and ack are never simultaneously nonzero; mem_req == (state==BUSY).

Test Plan:
1. Single request: from reset, req=0010, addr1=0x100, we=0; memory returns mem_ack with mem_rdata=0xDEADBEEF 3 cycles after mem_req rises. Required: gnt=0010 and mem_addr=0x100 at cycle 1; ack=0010 with rdata=0xDEADBEEF one cycle after mem_ack; err=0.
2. All requesting: req=1111 held, memory acks in 1 cycle. Required: grant order 0,1,2,3,0; one grant every 4 cycles; never two bits of gnt set.
3. Rotation: after a grant to requester 2, assert req=1001. Required: requester 3 is granted before requester 0.
4. Timeout: TIMEOUT=16, req=0100 write, mem_ack never asserted. Required: mem_req high exactly 16 cycles; then ack=0100, err=1, rdata=0; return to IDLE.
5. Reset mid-op: rst_b=0 during BUSY. Required: all outputs 0 immediately, with no clock needed; after release with req=1111, requester 0 is granted first.
6. Dropped request and stray ack: requester drops req and changes addr during BUSY; also pulse mem_ack while IDLE. Required: mem_addr holds the original value; ack is still issued for the dropped request; the IDLE mem_ack causes no output change.
